// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing defaults, coordinate width and small helpers for the VGA
// timing generator and the screen stage that decodes colour from sx/sy.
package vga_timing_gen_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_ACTIVE = 1'b0;

  function automatic int div_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Half-open window test lo <= v < hi on a coordinate.
  function automatic logic in_window(input logic [COORD_W-1:0] v, input int lo, input int hi);
    int vi;
    vi = int'(v);
    return (vi >= lo) && (vi < hi);
  endfunction

  function automatic logic sync_level(input logic asserted, input logic active);
    return asserted ? active : ~active;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick.sv
// Clock-enable divider: pix_en pulses for one clk every CLK_DIV clks.
module pixel_tick
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  generate
    if (CLK_DIV <= 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = clk ^ rst;
      assign pix_en = 1'b1;
    end else begin : g_div
      localparam int DIV_W = div_width(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          div_reg <= '0;
        end else if (div_reg == DIV_LAST) begin
          div_reg <= '0;
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end

      assign pix_en = (div_reg == DIV_LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel coordinates plus registered sync/de
// and line/frame start pulses, all coherent with sx/sy in the same clk.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] sx,
  output logic [COORD_W-1:0] sy,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
    end
  endgenerate

  pixel_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  logic [COORD_W-1:0] sx_reg, sx_next;
  logic [COORD_W-1:0] sy_reg, sy_next;
  logic hsync_reg, vsync_reg, de_reg, line_start_reg, frame_start_reg;
  logic line_wrap, frame_wrap;

  always_comb begin
    sx_next    = sx_reg;
    sy_next    = sy_reg;
    line_wrap  = pix_en && (sx_reg == H_LAST);
    frame_wrap = line_wrap && (sy_reg == V_LAST);
    if (pix_en) begin
      if (sx_reg == H_LAST) begin
        sx_next = '0;
        sy_next = (sy_reg == V_LAST) ? '0 : sy_reg + 1'b1;
      end else begin
        sx_next = sx_reg + 1'b1;
      end
    end
  end

  // Sync/de are decoded from the next position so they land with sx/sy.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_reg          <= H_LAST;
      sy_reg          <= V_LAST;
      hsync_reg       <= ~SYNC_ACTIVE;
      vsync_reg       <= ~SYNC_ACTIVE;
      de_reg          <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      sx_reg          <= sx_next;
      sy_reg          <= sy_next;
      hsync_reg       <= sync_level(in_window(sx_next, HS_START, HS_END), SYNC_ACTIVE);
      vsync_reg       <= sync_level(in_window(sy_next, VS_START, VS_END), SYNC_ACTIVE);
      de_reg          <= in_window(sx_next, 0, H_ACTIVE) && in_window(sy_next, 0, V_ACTIVE);
      line_start_reg  <= line_wrap;
      frame_start_reg <= frame_wrap;
    end
  end

  assign sx          = sx_reg;
  assign sy          = sy_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (15x10) so whole frames fit in
// a short run; one divided instance (active-low sync) and one CLK_DIV=1 instance.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 15
  localparam int VT = VA + VF + VS + VB;  // 10
  localparam int NPIX = HT * VT;          // 150

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0] sx_a, sy_a;
  logic pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0] sx_b, sy_b;

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(pe_a), .sx(sx_a), .sy(sy_a), .hsync(hs_a),
    .vsync(vs_a), .de(de_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pe_b), .sx(sx_b), .sy(sy_b), .hsync(hs_b),
    .vsync(vs_b), .de(de_b), .line_start(ls_b), .frame_start(fs_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Closed-form model: k = clks since reset release; every D clks one pixel
  // advance from the reset position (last pixel of the frame).
  function automatic int model(input int k, input int d, input bit sa);
    int adv, idx, x, y;
    bit pe, h, v, en, ls, fs;
    adv = k / d;
    idx = (NPIX - 1 + adv) % NPIX;
    x   = idx % HT;
    y   = idx / HT;
    pe  = (k % d) == d - 1;
    h   = (x >= HA + HF && x < HA + HF + HS) ? sa : !sa;
    v   = (y >= VA + VF && y < VA + VF + VS) ? sa : !sa;
    en  = (x < HA) && (y < VA);
    ls  = (k > 0) && (k % d == 0) && (x == 0);
    fs  = ls && (y == 0);
    return int'({pe, 10'(x), 10'(y), h, v, en, ls, fs});
  endfunction

  int k = 0;
  bit valid = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      k = 0;
      valid = 1'b1;
    end else if (valid) begin
      k++;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      chk("raster_a", int'({pe_a, sx_a, sy_a, hs_a, vs_a, de_a, ls_a, fs_a}), model(k, 4, 1'b0));
      chk("raster_b", int'({pe_b, sx_b, sy_b, hs_b, vs_b, de_b, ls_b, fs_b}), model(k, 1, 1'b1));
    end
  end

  // Period/count measurements over the first full frame of dut_a.
  bit meas_en = 1'b0;
  bit win;
  int nfs_a = 0, fs_t_a = -1, fs_per_a = -1, ls_t_a = -1, ls_per_a = -1;
  int fs_t_b = -1, fs_per_b = -1;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, ls_cnt = 0, pe_cnt = 0;

  always @(negedge clk) begin
    if (meas_en) begin
      win = (nfs_a == 0 && fs_a) || (nfs_a == 1 && !fs_a);
      if (win) begin
        de_cnt += int'(de_a && pe_a);
        hs_cnt += int'(!hs_a);
        vs_cnt += int'(!vs_a);
        ls_cnt += int'(ls_a);
        pe_cnt += int'(pe_a);
      end
      if (fs_a) begin
        if (fs_t_a >= 0 && fs_per_a < 0) fs_per_a = cyc - fs_t_a;
        fs_t_a = cyc;
        nfs_a++;
      end
      if (ls_a) begin
        if (ls_t_a >= 0 && ls_per_a < 0) ls_per_a = cyc - ls_t_a;
        ls_t_a = cyc;
      end
      if (fs_b) begin
        if (fs_t_b >= 0 && fs_per_b < 0) fs_per_b = cyc - fs_t_b;
        fs_t_b = cyc;
      end
    end
  end

  task automatic reset_state_checks(input string tag);
    chk({tag, "_sx"}, int'(sx_a), 14);
    chk({tag, "_sy"}, int'(sy_a), 9);
    chk({tag, "_hsync"}, int'(hs_a), 1);
    chk({tag, "_vsync"}, int'(vs_a), 1);
    chk({tag, "_de"}, int'(de_a), 0);
    chk({tag, "_pix_en"}, int'(pe_a), 0);
    chk({tag, "_pulses"}, int'({ls_a, fs_a}), 0);
    chk({tag, "_b_pix_en"}, int'(pe_b), 1);
    chk({tag, "_b_hsync"}, int'(hs_b), 0);
  endtask

  task automatic startup_checks(input string tag);
    @(negedge clk);
    chk({tag, "_b_sx"}, int'(sx_b), 0);
    chk({tag, "_b_frame_start"}, int'(fs_b), 1);
    chk({tag, "_a_hold1"}, int'(sx_a), 14);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_a_pix_en"}, int'(pe_a), 1);
    chk({tag, "_a_hold3"}, int'(sx_a), 14);
    @(negedge clk);
    chk({tag, "_a_sx0"}, int'(sx_a), 0);
    chk({tag, "_a_sy0"}, int'(sy_a), 0);
    chk({tag, "_a_frame_start"}, int'(fs_a), 1);
    chk({tag, "_a_line_start"}, int'(ls_a), 1);
    chk({tag, "_a_de"}, int'(de_a), 1);
    @(negedge clk);
    chk({tag, "_a_fs_one_clk"}, int'(fs_a), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset_state_checks("rst");
    rst = 1'b0;
    meas_en = 1'b1;
    startup_checks("start");
    repeat (1300) @(negedge clk);
    meas_en = 1'b0;

    // Reach (5,3) with divider phase 2, then reset for one clk.
    n = 0;
    while (!(k % 600 == 206) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached", int'(k % 600 == 206), 1);
    chk("midrst_sx", int'(sx_a), 5);
    chk("midrst_sy", int'(sy_a), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_state_checks("midrst");
    startup_checks("restart");
    repeat (50) @(negedge clk);

    chk("frame_period_a", fs_per_a, 600);
    chk("line_period_a", ls_per_a, 60);
    chk("lines_per_frame_a", ls_cnt, 10);
    chk("de_pixels_a", de_cnt, 48);
    chk("hsync_clks_a", hs_cnt, 120);
    chk("vsync_clks_a", vs_cnt, 120);
    chk("pix_en_per_frame_a", pe_cnt, 150);
    chk("frame_period_b", fs_per_b, 150);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
